// File: rtl/reg_file_pkg.sv
// Shared definitions for the parameterised register file.
// Holds the clear-sweep state encoding and the default widths.
package reg_file_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_t;
endpackage

// File: rtl/reg_file_param_if.sv
// Processor-side bus of the register file.
//   master: drives IN, INADDRESS, WRITE, BUSYWAIT, CLEAR, OUT1ADDRESS, OUT2ADDRESS;
//           receives OUT1, OUT2, CLEAR_BUSY
//   slave : the register file (opposite directions)
interface reg_file_param_if #(
  parameter int DATA_W = reg_file_pkg::DATA_W_DEF,
  parameter int ADDR_W = reg_file_pkg::ADDR_W_DEF
);
  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic              BUSYWAIT;
  logic              CLEAR;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              CLEAR_BUSY;

  modport master (
    output IN, INADDRESS, WRITE, BUSYWAIT, CLEAR, OUT1ADDRESS, OUT2ADDRESS,
    input  OUT1, OUT2, CLEAR_BUSY
  );

  modport slave (
    input  IN, INADDRESS, WRITE, BUSYWAIT, CLEAR, OUT1ADDRESS, OUT2ADDRESS,
    output OUT1, OUT2, CLEAR_BUSY
  );
endinterface

// File: rtl/reg_file_param_clear_sequencer.sv
// Clear-sweep sequencer: walks an address counter across every register.
// Ports:
//   CLK, RESET_N : clock, async active-low reset
//   CLEAR        : start a sweep (ignored while one is running)
//   CLEAR_BUSY   : registered, high while sweeping
//   CLR_ADDR     : register to zero on the coming edge
//   CLR_EN       : zero CLR_ADDR on the coming edge
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no sweep; CLEAR here zeroes r0 and starts one
// CLEARING | zero r[cnt] each edge, back to IDLE after last
module clear_sequencer
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CLEAR,
  output logic              CLEAR_BUSY,
  output logic [ADDR_W-1:0] CLR_ADDR,
  output logic              CLR_EN
);
  localparam logic [ADDR_W-1:0] LAST = '1;

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cnt        <= '0;
      CLEAR_BUSY <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CLEAR) begin
            state      <= CLEARING;
            cnt        <= ADDR_W'(1);
            CLEAR_BUSY <= 1'b1;
          end
        end
        CLEARING: begin
          if (cnt == LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            CLEAR_BUSY <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          CLEAR_BUSY <= 1'b0;
        end
      endcase
    end
  end

  // cnt rests at 0 in IDLE, so the starting edge zeroes r0 through the same path.
  assign CLR_ADDR = cnt;
  assign CLR_EN   = (state == CLEARING) | CLEAR;
endmodule

// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two combinational read ports
// with write-through bypass, optional hardwired-zero r0, sequential clear.
// Ports:
//   CLK, RESET_N : clock, async active-low reset (zeroes all registers)
//   bus          : reg_file_param_if slave (write/read/clear signals)
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  reg_file_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              clr_busy;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_en;
  logic              wr_qual;
  logic              wr_commit;

  clear_sequencer #(.ADDR_W(ADDR_W)) u_seq (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CLEAR      (bus.CLEAR),
    .CLEAR_BUSY (clr_busy),
    .CLR_ADDR   (clr_addr),
    .CLR_EN     (clr_en)
  );

  assign bus.CLEAR_BUSY = clr_busy;

  // RESET_N is part of the qualifier so the read ports show 0 during reset.
  assign wr_qual   = RESET_N & bus.WRITE & ~bus.BUSYWAIT & ~clr_busy;
  assign wr_commit = wr_qual & ~((ZERO_REG != 0) && (bus.INADDRESS == '0));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_en) begin
      // clear outranks a write presented on the CLEAR edge
      regs[clr_addr] <= '0;
    end else if (wr_commit) begin
      regs[bus.INADDRESS] <= bus.IN;
    end
  end

  always_comb begin
    bus.OUT1 = regs[bus.OUT1ADDRESS];
    if ((ZERO_REG != 0) && (bus.OUT1ADDRESS == '0)) bus.OUT1 = '0;
    else if (wr_qual && (bus.INADDRESS == bus.OUT1ADDRESS)) bus.OUT1 = bus.IN;
  end

  always_comb begin
    bus.OUT2 = regs[bus.OUT2ADDRESS];
    if ((ZERO_REG != 0) && (bus.OUT2ADDRESS == '0)) bus.OUT2 = '0;
    else if (wr_qual && (bus.INADDRESS == bus.OUT2ADDRESS)) bus.OUT2 = bus.IN;
  end
endmodule
